// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x W register file with two combinational read
// ports, one synchronous write port, a per-entry pending (scoreboard) bit,
// and a bulk-clear engine that zeroes one entry per cycle.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_scoreboard #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_synchronous_n,
    input  logic          write_enable,
    input  logic [AW-1:0] inp_write_address0,
    input  logic [W-1:0]  inp_write_data,
    input  logic [AW-1:0] inp_read_address0,
    input  logic [AW-1:0] inp_read_address1,
    output logic [W-1:0]  out_read_data0,
    output logic [W-1:0]  out_read_data1,
    output logic          out_read_pending0,
    output logic          out_read_pending1,
    input  logic          reserve_enable,
    input  logic [AW-1:0] inp_reserve_address,
    input  logic          clear_start,
    output logic          out_clear_busy
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic          wr_ok;
    logic          rsv_ok;

    // Write/reserve strobes only take effect while idle; in CLEAR they are dropped.
    assign wr_ok  = write_enable   && (state_q == IDLE);
    assign rsv_ok = reserve_enable && (state_q == IDLE);

    assign out_clear_busy = (state_q == CLEAR);

    // Clear FSM next state and sweep counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                // DEPTH-1 is all ones, so the last entry is reached when the counter saturates.
                if (clr_cnt_q == '1) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage and scoreboard bits: reset, clear sweep, or write/reserve.
    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
        end else if (state_q == CLEAR) begin
            mem[clr_cnt_q]     <= '0;
            pending[clr_cnt_q] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[inp_write_address0]     <= inp_write_data;
                pending[inp_write_address0] <= 1'b0;
            end
            // Placed after the write so a same-address reserve leaves pending set.
            if (rsv_ok) begin
                pending[inp_reserve_address] <= 1'b1;
            end
        end
    end

    // Combinational read ports, with optional same-cycle forwarding of the write.
    always_comb begin
        out_read_data0    = mem[inp_read_address0];
        out_read_data1    = mem[inp_read_address1];
        out_read_pending0 = pending[inp_read_address0];
        out_read_pending1 = pending[inp_read_address1];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (inp_read_address0 == inp_write_address0)) begin
            out_read_data0    = inp_write_data;
            out_read_pending0 = rsv_ok && (inp_reserve_address == inp_write_address0);
        end
        if (wr_ok && (inp_read_address1 == inp_write_address0)) begin
            out_read_data1    = inp_write_data;
            out_read_pending1 = rsv_ok && (inp_reserve_address == inp_write_address0);
        end
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int S_D0 = 0, S_D1 = 1, S_P0 = 2, S_P1 = 3, S_BUSY = 4,
                 S_WD0 = 5, S_WD1 = 6, S_WBUSY = 7;

  logic        rst_n;
  logic        we, res_en, clr;
  logic [3:0]  wa, ra0, ra1, res_addr;
  logic [15:0] wd, rd0, rd1;
  logic        p0, p1, busy;

  logic        w_we, w_res_en, w_clr;
  logic [4:0]  w_wa, w_ra0, w_ra1, w_res_addr;
  logic [31:0] w_wd, w_rd0, w_rd1;
  logic        w_p0, w_p1, w_busy;

  regfile_scoreboard dut (
    .clk(clk), .reset_synchronous_n(rst_n),
    .write_enable(we), .inp_write_address0(wa), .inp_write_data(wd),
    .inp_read_address0(ra0), .inp_read_address1(ra1),
    .out_read_data0(rd0), .out_read_data1(rd1),
    .out_read_pending0(p0), .out_read_pending1(p1),
    .reserve_enable(res_en), .inp_reserve_address(res_addr),
    .clear_start(clr), .out_clear_busy(busy)
  );

  regfile_scoreboard #(.W(32), .AW(5)) dut_wide (
    .clk(clk), .reset_synchronous_n(rst_n),
    .write_enable(w_we), .inp_write_address0(w_wa), .inp_write_data(w_wd),
    .inp_read_address0(w_ra0), .inp_read_address1(w_ra1),
    .out_read_data0(w_rd0), .out_read_data1(w_rd1),
    .out_read_pending0(w_p0), .out_read_pending1(w_p1),
    .reserve_enable(w_res_en), .inp_reserve_address(w_res_addr),
    .clear_start(w_clr), .out_clear_busy(w_busy)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.sel)
        S_D0:    act = {16'h0, rd0};
        S_D1:    act = {16'h0, rd1};
        S_P0:    act = {31'h0, p0};
        S_P1:    act = {31'h0, p1};
        S_BUSY:  act = {31'h0, busy};
        S_WD0:   act = w_rd0;
        S_WD1:   act = w_rd1;
        S_WBUSY: act = {31'h0, w_busy};
        default: act = 'x;
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    we = 0; res_en = 0; clr = 0; wa = 0; wd = 0; ra0 = 0; ra1 = 0; res_addr = 0;
    w_we = 0; w_res_en = 0; w_clr = 0; w_wa = 0; w_wd = 0; w_ra0 = 0; w_ra1 = 0; w_res_addr = 0;
    step();
    step();
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 16; i++) begin
      ra0 = 4'(i);
      ra1 = 4'(15 - i);
      expect_val("rst_d0", S_D0, 0);
      expect_val("rst_d1", S_D1, 0);
      expect_val("rst_p0", S_P0, 0);
      expect_val("rst_p1", S_P1, 0);
      expect_val("rst_busy", S_BUSY, 0);
      if (i == 0) begin
        w_ra0 = 5'd31;
        expect_val("rst_wide_d0", S_WD0, 0);
        expect_val("rst_wide_busy", S_WBUSY, 0);
      end
      step();
    end

    we = 1; wa = 4'd3; wd = 16'hBEEF; ra0 = 4'd3; ra1 = 4'd4;
    expect_val("wr_same_cycle_d0", S_D0, BYP ? 32'hBEEF : 32'h0);
    expect_val("wr_other_d1", S_D1, 0);
    step();
    we = 0; ra0 = 4'd3; ra1 = 4'd3;
    #1;
    total++;
    if (rd0 !== 16'hBEEF) begin
      bad++;
      $display("FAIL direct_rd3_d0: got %h want beef at %0t", rd0, $time);
    end
    total++;
    if (rd1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL direct_rd3_d1: got %h want beef at %0t", rd1, $time);
    end
    total++;
    if (p0 !== 1'b0 || p1 !== 1'b0) begin
      bad++;
      $display("FAIL direct_rd3_pending: got %b %b want 0 0 at %0t", p0, p1, $time);
    end
    expect_val("rd3_d0", S_D0, 32'hBEEF);
    expect_val("rd3_d1", S_D1, 32'hBEEF);
    expect_val("rd3_p0", S_P0, 0);
    expect_val("rd3_p1", S_P1, 0);
    step();

    res_en = 1; res_addr = 4'd5; ra0 = 4'd5;
    expect_val("rsv5_before_p0", S_P0, 0);
    step();
    res_en = 0;
    expect_val("rsv5_p0", S_P0, 1);
    expect_val("rsv5_d0", S_D0, 0);
    step();
    we = 1; wa = 4'd5; wd = 16'h1234;
    expect_val("wr5_same_p0", S_P0, BYP ? 32'h0 : 32'h1);
    expect_val("wr5_same_d0", S_D0, BYP ? 32'h1234 : 32'h0);
    step();
    we = 0;
    expect_val("wr5_p0", S_P0, 0);
    expect_val("wr5_d0", S_D0, 32'h1234);
    step();

    we = 1; wa = 4'd7; wd = 16'h7777; res_en = 1; res_addr = 4'd7; ra1 = 4'd7;
    expect_val("rw7_same_d1", S_D1, BYP ? 32'h7777 : 32'h0);
    expect_val("rw7_same_p1", S_P1, BYP ? 32'h1 : 32'h0);
    step();
    we = 0; res_en = 0;
    expect_val("rw7_d1", S_D1, 32'h7777);
    expect_val("rw7_p1", S_P1, 1);
    step();

    we = 1; wa = 4'd4; wd = 16'h1111;
    step();
    wd = 16'hA5A5; ra0 = 4'd4;
    expect_val("byp4_same_d0", S_D0, BYP ? 32'hA5A5 : 32'h1111);
    step();
    we = 0;
    expect_val("byp4_next_d0", S_D0, 32'hA5A5);
    step();

    for (int unsigned i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 16'(16'h1001 + i);
      step();
    end
    we = 0;
    res_en = 1; res_addr = 4'd2;
    step();
    res_addr = 4'd9;
    step();
    res_en = 0;
    ra0 = 4'd2; ra1 = 4'd9;
    expect_val("fill_p2", S_P0, 1);
    expect_val("fill_p9", S_P1, 1);
    expect_val("fill_d2", S_D0, 32'h1003);
    expect_val("fill_d9", S_D1, 32'h100A);
    expect_val("pre_clear_busy", S_BUSY, 0);
    clr = 1;
    step();
    clr = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      expect_val("clear_busy", S_BUSY, 1);
      if (k == 3) begin
        we = 1; wa = 4'd0; wd = 16'hFFFF; res_en = 1; res_addr = 4'd0; ra0 = 4'd0;
        expect_val("clear_no_bypass_d0", S_D0, 0);
        expect_val("clear_no_bypass_p0", S_P0, 0);
      end
      if (k == 4) begin
        we = 0; res_en = 0; ra0 = 4'd0; ra1 = 4'd9;
        expect_val("clear_drop_wr_d0", S_D0, 0);
        expect_val("clear_drop_rsv_p0", S_P0, 0);
        expect_val("clear_live_d9", S_D1, 32'h100A);
        expect_val("clear_live_p9", S_P1, 1);
      end
      if (k == 5) clr = 1;
      if (k == 6) clr = 0;
      if (k == 10) begin
        ra0 = 4'd2; ra1 = 4'd9;
        expect_val("clear_done_d2", S_D0, 0);
        expect_val("clear_done_p2", S_P0, 0);
        expect_val("clear_done_d9", S_D1, 0);
        expect_val("clear_done_p9", S_P1, 0);
      end
      step();
    end
    expect_val("clear_end_busy", S_BUSY, 0);
    clr = 1;
    step();
    clr = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      ra0 = 4'(k); ra1 = 4'(15 - k);
      expect_val("clear2_busy", S_BUSY, 1);
      expect_val("after_clear_d0", S_D0, 0);
      expect_val("after_clear_p0", S_P0, 0);
      expect_val("after_clear_d1", S_D1, 0);
      expect_val("after_clear_p1", S_P1, 0);
      step();
    end
    expect_val("clear2_end_busy", S_BUSY, 0);
    step();

    for (int unsigned i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 16'(16'h2001 + i);
      step();
    end
    we = 0;
    res_en = 1; res_addr = 4'd12;
    step();
    res_en = 0;
    clr = 1;
    step();
    clr = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      expect_val("midclr_busy", S_BUSY, 1);
      step();
    end
    rst_n = 0;
    ra0 = 4'd15;
    expect_val("midclr_6th_busy", S_BUSY, 1);
    expect_val("midclr_6th_d15", S_D0, 32'h2010);
    step();
    rst_n = 1;
    for (int unsigned k = 0; k < 16; k++) begin
      ra0 = 4'(k); ra1 = 4'(15 - k);
      expect_val("postrst_busy", S_BUSY, 0);
      expect_val("postrst_d0", S_D0, 0);
      expect_val("postrst_d1", S_D1, 0);
      expect_val("postrst_p0", S_P0, 0);
      expect_val("postrst_p1", S_P1, 0);
      step();
    end
    clr = 1;
    step();
    clr = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      expect_val("reclr_busy", S_BUSY, 1);
      step();
    end
    expect_val("reclr_end_busy", S_BUSY, 0);
    step();

    w_we = 1; w_wa = 5'd31; w_wd = 32'hDEADBEEF;
    step();
    w_we = 0; w_ra0 = 5'd31; w_ra1 = 5'd30;
    expect_val("wide_d31", S_WD0, 32'hDEADBEEF);
    expect_val("wide_d30", S_WD1, 0);
    expect_val("wide_idle_busy", S_WBUSY, 0);
    w_clr = 1;
    step();
    w_clr = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      expect_val("wide_clear_busy", S_WBUSY, 1);
      if (k == 31) expect_val("wide_live_d31", S_WD0, 32'hDEADBEEF);
      step();
    end
    expect_val("wide_clear_end_busy", S_WBUSY, 0);
    expect_val("wide_cleared_d31", S_WD0, 0);
    step();
    step();

    #1;
    total++;
    if (w_rd0 !== 32'h0) begin
      bad++;
      $display("FAIL direct_wide_d31: got %h want 0 at %0t", w_rd0, $time);
    end
    total++;
    if (w_busy !== 1'b0) begin
      bad++;
      $display("FAIL direct_wide_busy: got %b want 0 at %0t", w_busy, $time);
    end
    total++;
    if (rd0 !== 16'h0 || rd1 !== 16'h0) begin
      bad++;
      $display("FAIL direct_final_data: got %h %h want 0 0 at %0t", rd0, rd1, $time);
    end
    total++;
    if (p0 !== 1'b0 || p1 !== 1'b0) begin
      bad++;
      $display("FAIL direct_final_pending: got %b %b want 0 0 at %0t", p0, p1, $time);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL direct_final_busy: got %b want 0 at %0t", busy, $time);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
